// File: rtl/aes_result_sequencer.sv
// Reorders results from the three AES encrypt engines back into issue order for the host stream.
// Optional head-entry timeout is compiled in with the AES_SEQ_TIMEOUT_EN macro.
module aes_result_sequencer #(
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              issue_valid,
    input  logic [1:0]        issue_id,
    input  logic [2:0]        done,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        order_cnt,
    output logic              proto_err,
    output logic              timeout_err
);

    localparam int unsigned QD = 3;
    localparam int unsigned PW = 2;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]        id_q     [QD];
    logic [1:0]        id_d     [QD];
    logic [DATA_W-1:0] buf_q    [QD];
    logic [DATA_W-1:0] buf_d    [QD];
    logic [DATA_W-1:0] data_c   [QD];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [QD-1:0]     full_q, full_d;
    logic              proto_err_q, proto_err_d;

    logic [1:0]        head_idx_c;
    logic              out_valid_c;
    logic              pop_c;
    logic              discard_c;
    logic              deq_c;
    logic              push_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign data_c[0] = data_1;
    assign data_c[1] = data_2;
    assign data_c[2] = data_3;

    // Queue only ever holds ids 1..3, so head_idx_c is always a valid engine index
    assign head_idx_c  = 2'(id_q[rd_ptr_q] - 2'd1);
    assign out_valid_c = (cnt_q != 2'd0) && full_q[head_idx_c];
    assign pop_c       = out_valid_c && out_ready;
    assign deq_c       = pop_c || discard_c;
    assign push_c      = issue_valid && (issue_id != 2'd0) && ((cnt_q != 2'(QD)) || deq_c);

    assign out_valid = out_valid_c;
    assign out_data  = out_valid_c ? buf_q[head_idx_c] : '0;
    assign order_cnt = cnt_q;
    assign proto_err = proto_err_q;

    // Order queue, result buffers and protocol error tracking
    always_comb begin
        id_d        = id_q;
        buf_d       = buf_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        proto_err_d = proto_err_q;

        if (issue_valid && ((issue_id == 2'd0) || ((cnt_q == 2'(QD)) && !deq_c))) begin
            proto_err_d = 1'b1;
        end

        if (push_c) begin
            id_d[wr_ptr_q] = issue_id;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (deq_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_c, deq_c})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // A done on the engine being popped refills its buffer instead of overwriting
        for (int k = 0; k < int'(QD); k++) begin
            if (pop_c && (head_idx_c == 2'(k))) begin
                full_d[k] = 1'b0;
            end
            if (done[k]) begin
                if (full_q[k] && !(pop_c && (head_idx_c == 2'(k)))) begin
                    proto_err_d = 1'b1;
                end else begin
                    buf_d[k]  = data_c[k];
                    full_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < int'(QD); k++) begin
                id_q[k]  <= '0;
                buf_q[k] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            id_q        <= id_d;
            buf_q       <= buf_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_err_q, timeout_err_d;

    // Head wait counter; expiry drops the head entry without producing output
    always_comb begin
        tmo_d         = '0;
        timeout_err_d = timeout_err_q;
        discard_c     = 1'b0;
        if ((cnt_q != 2'd0) && !full_q[head_idx_c]) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                discard_c     = 1'b1;
                timeout_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign discard_c   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_result_sequencer.sv
// Directed bench for aes_result_sequencer: ordering, backpressure, full queue, overwrite, reset, timeout.
module tb_aes_result_sequencer;

    localparam int unsigned DW = 128;

    logic          clk;
    logic          n_rst;
    logic          issue_valid;
    logic [1:0]    issue_id;
    logic [2:0]    done;
    logic [DW-1:0] data_1, data_2, data_3;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    order_cnt;
    logic          proto_err;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] VA = 128'h0000_0000_0000_0000_0000_0000_0000_00A1;
    localparam logic [DW-1:0] VB = 128'h1111_2222_3333_4444_5555_6666_7777_88B2;
    localparam logic [DW-1:0] VC = 128'hC3C3_0000_FFFF_1234_0000_0000_0000_00C3;
    localparam logic [DW-1:0] VD = 128'hDDDD_0000_0000_0000_0000_0000_0000_00D4;
    localparam logic [DW-1:0] VE = 128'hEEEE_EEEE_0000_0000_0000_0000_0000_00E5;
    localparam logic [DW-1:0] VX = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    localparam logic [DW-1:0] VY = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] VF = 128'hF0F0_0000_0000_0000_0000_0000_0000_00F6;

    aes_result_sequencer #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .issue_valid(issue_valid),
        .issue_id   (issue_id),
        .done       (done),
        .data_1     (data_1),
        .data_2     (data_2),
        .data_3     (data_3),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .order_cnt  (order_cnt),
        .proto_err  (proto_err),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst       = 1'b0;
        issue_valid = 1'b0;
        issue_id    = 2'd0;
        done        = 3'b000;
        data_1      = '0;
        data_2      = '0;
        data_3      = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_order_cnt", DW'(order_cnt), '0);
        chk("rst_proto_err", DW'(proto_err), '0);
        chk("rst_timeout_err", DW'(timeout_err), '0);
        n_rst = 1'b1;
        tick();

        // Test 1: issue 1,2,3; results arrive 3,1,2; output must be B,C,A
        issue_valid = 1'b1; issue_id = 2'd1; tick();
        issue_id = 2'd2; tick();
        issue_id = 2'd3; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        chk("t1_cnt3", DW'(order_cnt), DW'(3));
        chk("t1_no_valid", DW'(out_valid), '0);
        done = 3'b100; data_3 = VA; tick();
        chk("t1_no_overtake", DW'(out_valid), '0);
        chk("t1_cnt3_b", DW'(order_cnt), DW'(3));
        done = 3'b001; data_1 = VB; tick();
        chk("t1_valid_b", DW'(out_valid), DW'(1));
        chk("t1_data_b", out_data, VB);
        done = 3'b010; data_2 = VC; out_ready = 1'b1; tick();
        done = 3'b000;
        chk("t1_data_c", out_data, VC);
        chk("t1_cnt2", DW'(order_cnt), DW'(2));
        tick();
        chk("t1_data_a", out_data, VA);
        chk("t1_cnt1", DW'(order_cnt), DW'(1));
        tick();
        out_ready = 1'b0;
        chk("t1_cnt0", DW'(order_cnt), '0);
        chk("t1_empty_valid", DW'(out_valid), '0);
        chk("t1_empty_data", out_data, '0);

        // Test 2: backpressure holds output stable, then exactly one pop
        issue_valid = 1'b1; issue_id = 2'd2; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        done = 3'b010; data_2 = VD; tick();
        done = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", DW'(out_valid), DW'(1));
            chk("t2_hold_data", out_data, VD);
            tick();
        end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("t2_popped_cnt", DW'(order_cnt), '0);
        chk("t2_popped_valid", DW'(out_valid), '0);
        tick();
        chk("t2_single_pop", DW'(order_cnt), '0);
        chk("t2_no_err", DW'(proto_err), '0);

        // Test 3: push into full queue dropped, push with simultaneous pop accepted
        issue_valid = 1'b1; issue_id = 2'd1; tick();
        issue_id = 2'd2; tick();
        issue_id = 2'd3; tick();
        chk("t3_full_no_err", DW'(proto_err), '0);
        issue_id = 2'd1; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        chk("t3_drop_err", DW'(proto_err), DW'(1));
        chk("t3_drop_cnt", DW'(order_cnt), DW'(3));
        done = 3'b001; data_1 = VE; tick();
        done = 3'b000;
        chk("t3_head_e", out_data, VE);
        issue_valid = 1'b1; issue_id = 2'd1; out_ready = 1'b1; tick();
        issue_valid = 1'b0; issue_id = 2'd0; out_ready = 1'b0;
        chk("t3_pushpop_cnt", DW'(order_cnt), DW'(3));
        chk("t3_pushpop_err", DW'(proto_err), DW'(1));
        chk("t3_new_head_wait", DW'(out_valid), '0);
        do_reset();
        chk("t3_rst_err", DW'(proto_err), '0);
        chk("t3_rst_cnt", DW'(order_cnt), '0);

        // Test 4: buffer overwrite keeps first value; id 0 is illegal
        issue_valid = 1'b1; issue_id = 2'd1; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        done = 3'b001; data_1 = VX; tick();
        chk("t4_first_no_err", DW'(proto_err), '0);
        data_1 = VY; tick();
        done = 3'b000;
        chk("t4_keep_x", out_data, VX);
        chk("t4_ovw_err", DW'(proto_err), DW'(1));
        do_reset();
        chk("t4_rst_err", DW'(proto_err), '0);
        issue_valid = 1'b1; issue_id = 2'd0; tick();
        issue_valid = 1'b0;
        chk("t4_id0_err", DW'(proto_err), DW'(1));
        chk("t4_id0_cnt", DW'(order_cnt), '0);
        do_reset();

        // Test 5: reset mid-stream clears queue and buffers
        issue_valid = 1'b1; issue_id = 2'd1; tick();
        issue_id = 2'd2; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        done = 3'b010; data_2 = VF; tick();
        done = 3'b000;
        chk("t5_pre_cnt", DW'(order_cnt), DW'(2));
        chk("t5_pre_valid", DW'(out_valid), '0);
        n_rst = 1'b0; tick();
        chk("t5_rst_cnt", DW'(order_cnt), '0);
        chk("t5_rst_valid", DW'(out_valid), '0);
        chk("t5_rst_data", out_data, '0);
        chk("t5_rst_err", DW'(proto_err), '0);
        n_rst = 1'b1;
        issue_valid = 1'b1; issue_id = 2'd2; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        chk("t5_buf_cleared", DW'(out_valid), '0);
        chk("t5_cnt1", DW'(order_cnt), DW'(1));
        do_reset();

        // Test 6: head with no result; drops after 8 cycles only when timeout is built in
        issue_valid = 1'b1; issue_id = 2'd2; tick();
        issue_valid = 1'b0; issue_id = 2'd0;
        for (int i = 0; i < 7; i++) begin
            chk("t6_wait_cnt", DW'(order_cnt), DW'(1));
            chk("t6_wait_valid", DW'(out_valid), '0);
            tick();
        end
        chk("t6_last_wait_cnt", DW'(order_cnt), DW'(1));
        chk("t6_last_wait_err", DW'(timeout_err), '0);
        tick();
        chk("t6_never_valid", DW'(out_valid), '0);
`ifdef AES_SEQ_TIMEOUT_EN
        chk("t6_expired_cnt", DW'(order_cnt), '0);
        chk("t6_timeout_err", DW'(timeout_err), DW'(1));
`else
        chk("t6_stays_cnt", DW'(order_cnt), DW'(1));
        chk("t6_no_timeout_err", DW'(timeout_err), '0);
`endif
        for (int i = 0; i < 10; i++) tick();
`ifdef AES_SEQ_TIMEOUT_EN
        chk("t6_sticky_tmo", DW'(timeout_err), DW'(1));
`else
        chk("t6_still_waiting", DW'(order_cnt), DW'(1));
`endif
        chk("t6_no_proto_err", DW'(proto_err), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
